// File: rtl/seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle add/subtract unit. The operands are latched on START and summed
//   CHUNK bits per clock. The carry between chunks is kept in a register, so
//   the combinational carry chain is only CHUNK bits long. The result and its
//   flags are published together with a one-cycle DONE pulse.
//
// Parameters
//   WIDTH   operand/result width in bits
//   CHUNK   bits summed per clock; must divide WIDTH (1 <= CHUNK <= WIDTH)
//
// Ports
//   CLK      in   clock, rising-edge active
//   RESET    in   asynchronous, active-high reset
//   START    in   request; sampled only while idle
//   SUB      in   0: ADD_a + ADD_b, 1: ADD_a - ADD_b (sampled with START)
//   ADD_a    in   operand A (sampled with START)
//   ADD_b    in   operand B (sampled with START)
//   ADD_out  out  registered result, held until the next completion
//   COUT     out  carry out of the MSB (for subtract: 1 = no borrow)
//   OVF      out  two's-complement signed overflow
//   BUSY     out  operation in progress
//   DONE     out  one-cycle pulse when ADD_out/COUT/OVF have been updated
// -----------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] ADD_a,
  input  logic [WIDTH-1:0] ADD_b,
  output logic [WIDTH-1:0] ADD_out,
  output logic             COUT,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // B already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;  // partial sum assembled chunk by chunk
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // One CHUNK-wide slice of the addition; this is the only carry chain.
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             last_chunk;

  assign {chunk_c, chunk_s} = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
                            + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, carry_q};

  assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          // Subtract as A + ~B + 1: invert B here, inject the +1 as carry-in.
          a_d     = ADD_a;
          b_d     = ADD_b ^ {WIDTH{SUB}};
          carry_d = SUB;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d[cnt_q*CHUNK +: CHUNK] = chunk_s;
        carry_d = chunk_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          // Overflow: both addends share a sign the result does not have.
          out_d   = sum_d;
          cout_d  = chunk_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // NOTE: the operand latches and partial sum are reset too, not only the
      // control state, so an aborted operation leaves no stale data behind.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ADD_out = out_q;
  assign COUT    = cout_q;
  assign OVF     = ovf_q;
  assign BUSY    = (state_q == S_RUN);
  assign DONE    = done_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Three instances of seq_chunk_adder (CHUNK = 8, 1, 32; WIDTH = 32) share
//   clock and reset. Directed and random operations are issued per instance;
//   each issue pushes the reference result and its expected DONE cycle into a
//   per-instance queue, and a per-instance monitor pops and compares on DONE.
// -----------------------------------------------------------------------------
module tb_seq_chunk_adder;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start [3];
  logic         sub   [3];
  logic [W-1:0] a     [3];
  logic [W-1:0] b     [3];
  logic [W-1:0] sum   [3];
  logic         cout  [3];
  logic         ovf   [3];
  logic         busy  [3];
  logic         done  [3];

  exp_t        exp_q [3][$];
  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nch(input int idx);
    return (idx == 0) ? 4 : ((idx == 1) ? 32 : 1);
  endfunction

  // Reference: wide integer arithmetic, no chunking.
  function automatic exp_t model(input logic s, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t              e;
    longint            sx, sy, res;
    longint unsigned   ux, uy;
    logic [W-1:0]      r32;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ux  = longint'(x);
    uy  = longint'(y);
    res = s ? (sx - sy) : (sx + sy);
    r32 = res[W-1:0];
    e.sum  = r32;
    e.ovf  = (res != longint'($signed(r32)));
    e.cout = s ? (ux >= uy) : ((ux + uy) > 64'h0000_0000_FFFF_FFFF);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 1 : 32);

    seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) u_dut (
      .CLK     (clk),
      .RESET   (rst),
      .START   (start[g]),
      .SUB     (sub[g]),
      .ADD_a   (a[g]),
      .ADD_b   (b[g]),
      .ADD_out (sum[g]),
      .COUT    (cout[g]),
      .OVF     (ovf[g]),
      .BUSY    (busy[g]),
      .DONE    (done[g])
    );

    exp_t e;
    always @(negedge clk) begin
      if (!rst && done[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("dut%0d unexpected DONE", g), 64'd1, 64'd0);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("dut%0d sum", g),      64'(sum[g]),  64'(e.sum));
          check($sformatf("dut%0d cout", g),     64'(cout[g]), 64'(e.cout));
          check($sformatf("dut%0d ovf", g),      64'(ovf[g]),  64'(e.ovf));
          check($sformatf("dut%0d done cyc", g), 64'(cyc),     64'(e.cyc));
          check($sformatf("dut%0d busy@done", g), 64'(busy[g]), 64'd0);
        end
      end
    end
  end

  // Called just after a negedge. START is sampled on the next rising edge;
  // operands are scrambled right after to show they were latched.
  task automatic do_op(input int idx, input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    exp_t e;
    e = model(s, x, y);
    e.cyc = cyc + 1 + nch(idx);
    exp_q[idx].push_back(e);
    start[idx] = 1'b1;
    sub[idx]   = s;
    a[idx]     = x;
    b[idx]     = y;
    @(negedge clk); #1;
    start[idx] = 1'b0;
    sub[idx]   = 1'($urandom_range(0, 1));
    a[idx]     = $urandom;
    b[idx]     = $urandom;
    check($sformatf("dut%0d busy after start", idx), 64'(busy[idx]), 64'd1);
  endtask

  // Returns just after the negedge of the DONE cycle that empties the queue.
  task automatic wait_drain(input int idx);
    int n = 0;
    while (exp_q[idx].size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check($sformatf("dut%0d drain timeout", idx), 64'(exp_q[idx].size()), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic random_ops(input int idx, input int n_ops);
    logic [W-1:0] specials [4];
    logic [W-1:0] x, y;
    specials[0] = 32'h0000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    for (int i = 0; i < n_ops; i++) begin
      x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      do_op(idx, 1'($urandom_range(0, 1)), x, y);
      wait_drain(idx);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      sub[i]   = 1'b0;
      a[i]     = '0;
      b[i]     = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("reset sum",  64'(sum[0]),  64'd0);
    check("reset cout", 64'(cout[0]), 64'd0);
    check("reset busy", 64'(busy[0]), 64'd0);
    check("reset done", 64'(done[0]), 64'd0);
    rst = 1'b0;
    idle(2);

    // Directed cases on the CHUNK=8 instance.
    do_op(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001); wait_drain(0);
    do_op(0, 1'b1, 32'd5, 32'd7);                 wait_drain(0);
    do_op(0, 1'b1, 32'd7, 32'd5);                 wait_drain(0);
    do_op(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001); wait_drain(0);
    do_op(0, 1'b1, 32'h8000_0000, 32'h0000_0001); wait_drain(0);

    // START while busy is ignored; START in the DONE cycle is accepted.
    do_op(0, 1'b0, 32'd1, 32'd2);
    start[0] = 1'b1; a[0] = 32'd9; b[0] = 32'd9; sub[0] = 1'b0;
    @(negedge clk); #1;
    start[0] = 1'b0;
    wait_drain(0);
    do_op(0, 1'b0, 32'd10, 32'd20);
    wait_drain(0);

    // Abort in the second RUN cycle; outputs clear without a clock edge.
    do_op(0, 1'b0, 32'h1234_5678, 32'h1111_1111);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_q[0].delete();
    check("abort sum",  64'(sum[0]),  64'd0);
    check("abort cout", 64'(cout[0]), 64'd0);
    check("abort ovf",  64'(ovf[0]),  64'd0);
    check("abort busy", 64'(busy[0]), 64'd0);
    check("abort done", 64'(done[0]), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle(6);
    do_op(0, 1'b0, 32'h1234_5678, 32'h1111_1111); wait_drain(0);

    // Carry-chain cases on CHUNK=1 and CHUNK=32.
    for (int i = 1; i < 3; i++) begin
      do_op(i, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001); wait_drain(i);
      do_op(i, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001); wait_drain(i);
      do_op(i, 1'b1, 32'd5, 32'd7);                 wait_drain(i);
    end

    // Random traffic on all three instances concurrently.
    fork
      random_ops(0, 40);
      random_ops(1, 20);
      random_ops(2, 60);
    join
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
